// File: rtl/fb_lock_pkg.sv
// Shared types and range-compare helper for the feedback-clock frequency lock detector.
package fb_lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        RANGE_OK,
        RANGE_FAST,
        RANGE_SLOW
    } range_t;

    localparam int CMP_W = 34;

    // Lower bound clamps at zero so a small nominal count with a wide tolerance cannot wrap.
    function automatic range_t in_range(
        input logic [CMP_W-1:0] count,
        input logic [CMP_W-1:0] expectedVal,
        input logic [CMP_W-1:0] tol
    );
        logic [CMP_W-1:0] hiBound;
        logic [CMP_W-1:0] loBound;
        hiBound = expectedVal + tol;
        loBound = (expectedVal < tol) ? '0 : (expectedVal - tol);
        if (count > hiBound) begin
            return RANGE_FAST;
        end else if (count < loBound) begin
            return RANGE_SLOW;
        end else begin
            return RANGE_OK;
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a history flop, producing a one-cycle pulse per rising edge
// of an asynchronous input.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/fb_lock_detector.sv
// Frequency-lock detector: counts feedback-clock edges per fixed window and declares lock
// after LOCK_COUNT consecutive in-tolerance windows.
module fb_lock_detector #(
    parameter int WINDOW     = 150,
    parameter int EXPECTED   = 10,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             fb_clk_in,
    input  logic             enable_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid_out,
    output logic             too_fast_out,
    output logic             too_slow_out,
    output logic             lock_out
);

    import fb_lock_pkg::*;

    localparam int WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [WIN_W-1:0]    WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_COUNT);

    state_t              r_state;
    logic [WIN_W-1:0]    r_win;
    logic [CNT_W-1:0]    r_edges;
    logic [STREAK_W-1:0] r_streak;

    logic                w_edge;
    logic [CNT_W:0]      w_edgeSum;
    logic [CNT_W-1:0]    w_final;
    range_t              w_range;
    logic [STREAK_W-1:0] w_streakNext;

    sync_edge_detect u_sync (
        .i_clk   (clock_in),
        .i_reset (reset_in),
        .i_async (fb_clk_in),
        .o_rise  (w_edge)
    );

    // w_final includes an edge seen this cycle, so a terminal-cycle edge lands in the closing window.
    always_comb begin
        w_edgeSum    = {1'b0, r_edges} + {{CNT_W{1'b0}}, w_edge};
        w_final      = w_edgeSum[CNT_W] ? {CNT_W{1'b1}} : w_edgeSum[CNT_W-1:0];
        w_range      = in_range(CMP_W'({1'b0, w_final}), CMP_W'(EXPECTED), CMP_W'(TOL));
        w_streakNext = '0;
        if (w_range == RANGE_OK) begin
            w_streakNext = (r_streak == STREAK_MAX) ? STREAK_MAX : (r_streak + STREAK_W'(1));
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state         <= IDLE;
            r_win           <= '0;
            r_edges         <= '0;
            r_streak        <= '0;
            count_out       <= '0;
            count_valid_out <= 1'b0;
            too_fast_out    <= 1'b0;
            too_slow_out    <= 1'b0;
            lock_out        <= 1'b0;
        end else begin
            count_valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_win    <= '0;
                    r_edges  <= '0;
                    r_streak <= '0;
                    lock_out <= 1'b0;
                    if (enable_in) begin
                        r_state <= ACQUIRE;
                    end
                end
                ACQUIRE, LOCKED: begin
                    // Disabling abandons the partial window but keeps the last reported count and flags.
                    if (!enable_in) begin
                        r_state  <= IDLE;
                        r_win    <= '0;
                        r_edges  <= '0;
                        r_streak <= '0;
                        lock_out <= 1'b0;
                    end else if (r_win == WIN_LAST) begin
                        r_win           <= '0;
                        r_edges         <= '0;
                        count_out       <= w_final;
                        count_valid_out <= 1'b1;
                        too_fast_out    <= (w_range == RANGE_FAST);
                        too_slow_out    <= (w_range == RANGE_SLOW);
                        r_streak        <= w_streakNext;
                        lock_out        <= (w_streakNext == STREAK_MAX);
                        r_state         <= (w_streakNext == STREAK_MAX) ? LOCKED : ACQUIRE;
                    end else begin
                        r_win   <= r_win + WIN_W'(1);
                        r_edges <= w_final;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
